// File: rtl/csr_access_unit.sv
// csr_access_unit: sequences CSR read-modify-write, ECALL trap entry and MRET return
// against a CSR file with one combinational read port and one write port.
module csr_access_unit #(
    parameter logic [11:0] MTVEC_ADDR  = 12'h305,
    parameter logic [11:0] MEPC_ADDR   = 12'h341,
    parameter logic [11:0] MCAUSE_ADDR = 12'h342,
    parameter logic [31:0] ECALL_CAUSE = 32'd11
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_req_valid,
    output logic        o_req_ready,
    input  logic [1:0]  i_req_kind,
    input  logic [2:0]  i_req_funct3,
    input  logic [11:0] i_req_csr,
    input  logic [31:0] i_req_src,
    input  logic        i_req_src_zero,
    input  logic [31:0] i_req_pc,
    output logic        o_resp_valid,
    input  logic        i_resp_ready,
    output logic [31:0] o_resp_rdata,
    output logic        o_resp_redirect,
    output logic [31:0] o_resp_pc,
    output logic        o_resp_illegal,
    output logic [11:0] o_csr_addr_r,
    input  logic [31:0] i_csr_data_r,
    output logic [11:0] o_csr_addr_w,
    output logic [31:0] o_csr_data_w,
    output logic        o_csr_we
);
    typedef enum logic [2:0] {IDLE, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, RESP} state_t;

    state_t      r_state;
    logic [2:0]  r_funct3;
    logic [11:0] r_csr;
    logic [31:0] r_src;
    logic        r_src_zero;
    logic [31:0] r_pc;
    logic        r_resp_valid;
    logic [31:0] r_resp_rdata;
    logic        r_resp_redirect;
    logic [31:0] r_resp_pc;
    logic        r_resp_illegal;

    logic        w_rw;
    logic        w_rs;
    logic        w_intent;
    logic        w_illegal;
    logic        w_op_we;
    logic [31:0] w_new;
    logic [31:0] w_vec_pc;

    // funct3[2] only selects register vs immediate source, which arrives pre-resolved in src
    assign w_rw      = r_funct3[1:0] == 2'b01;
    assign w_rs      = r_funct3[1:0] == 2'b10;
    assign w_intent  = w_rw || !r_src_zero;
    assign w_illegal = (r_funct3[1:0] == 2'b00) || (w_intent && r_csr[11:10] == 2'b11);
    assign w_op_we   = (r_state == CSR_WR) && w_intent && !w_illegal;
    assign w_new     = w_rw ? r_src : w_rs ? (i_csr_data_r | r_src) : (i_csr_data_r & ~r_src);
    assign w_vec_pc  = {i_csr_data_r[31:2], 2'b00};

    assign o_req_ready     = r_state == IDLE;
    assign o_resp_valid    = r_resp_valid;
    assign o_resp_rdata    = r_resp_rdata;
    assign o_resp_redirect = r_resp_redirect;
    assign o_resp_pc       = r_resp_pc;
    assign o_resp_illegal  = r_resp_illegal;

    // Read data is combinational, so the CSR port is driven straight from the state
    always_comb begin
        o_csr_addr_r = r_state == CSR_WR   ? r_csr :
                       r_state == TRAP_VEC ? MTVEC_ADDR :
                       r_state == MRET_RD  ? MEPC_ADDR : 12'h000;
        o_csr_we     = w_op_we || r_state == TRAP_EPC || r_state == TRAP_CAUSE;
        o_csr_addr_w = w_op_we                ? r_csr :
                       r_state == TRAP_EPC   ? MEPC_ADDR :
                       r_state == TRAP_CAUSE ? MCAUSE_ADDR : 12'h000;
        o_csr_data_w = w_op_we                ? w_new :
                       r_state == TRAP_EPC   ? r_pc :
                       r_state == TRAP_CAUSE ? ECALL_CAUSE : 32'h0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state         <= IDLE;
            r_funct3        <= 3'b000;
            r_csr           <= 12'h000;
            r_src           <= 32'h0;
            r_src_zero      <= 1'b0;
            r_pc            <= 32'h0;
            r_resp_valid    <= 1'b0;
            r_resp_rdata    <= 32'h0;
            r_resp_redirect <= 1'b0;
            r_resp_pc       <= 32'h0;
            r_resp_illegal  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: if (i_req_valid) begin
                    r_funct3        <= i_req_funct3;
                    r_csr           <= i_req_csr;
                    r_src           <= i_req_src;
                    r_src_zero      <= i_req_src_zero;
                    r_pc            <= i_req_pc;
                    r_resp_rdata    <= 32'h0;
                    r_resp_pc       <= 32'h0;
                    r_resp_redirect <= 1'b0;
                    r_resp_illegal  <= i_req_kind == 2'd3;
                    r_resp_valid    <= i_req_kind == 2'd3;
                    r_state         <= i_req_kind == 2'd0 ? CSR_WR :
                                       i_req_kind == 2'd1 ? TRAP_EPC :
                                       i_req_kind == 2'd2 ? MRET_RD : RESP;
                end
                CSR_WR: begin
                    r_resp_rdata   <= w_illegal ? 32'h0 : i_csr_data_r;
                    r_resp_illegal <= w_illegal;
                    r_resp_valid   <= 1'b1;
                    r_state        <= RESP;
                end
                TRAP_EPC:   r_state <= TRAP_CAUSE;
                TRAP_CAUSE: r_state <= TRAP_VEC;
                TRAP_VEC, MRET_RD: begin
                    r_resp_pc       <= w_vec_pc;
                    r_resp_redirect <= 1'b1;
                    r_resp_valid    <= 1'b1;
                    r_state         <= RESP;
                end
                RESP: if (i_resp_ready) begin
                    r_resp_valid    <= 1'b0;
                    r_resp_redirect <= 1'b0;
                    r_resp_illegal  <= 1'b0;
                    r_state         <= IDLE;
                end
                default: r_state <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/csr_access_unit.md
Name: csr_access_unit

Overview:
- Initiator/master for the CSR register file's single read port and single write port.
- Accepts one CSR instruction, ECALL or MRET per handshake from the execute stage.
- Performs the read-modify-write or the trap/return CSR sequence, then returns the old value and/or a redirect PC to the pipeline.
- Sits between execute and the CSR file; it is the only driver of the CSR write port.

Parameters:
- MTVEC_ADDR, 12'h305, trap vector CSR address
- MEPC_ADDR, 12'h341, exception PC CSR address
- MCAUSE_ADDR, 12'h342, cause CSR address
- ECALL_CAUSE, 32'd11, value written to mcause on ECALL (M-mode ecall)

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- req_valid  in  1  request valid
- req_ready  out  1  unit can accept a request
- req_kind  in  2  0=CSR op, 1=ECALL, 2=MRET, 3=reserved
- req_funct3  in  3  CSR op encoding: 001 RW, 010 RS, 011 RC, 101 RWI, 110 RSI, 111 RCI
- req_csr  in  12  target CSR address
- req_src  in  32  rs1 value, or zimm already zero-extended
- req_src_zero  in  1  rs1 index / zimm field is zero
- req_pc  in  32  PC of the instruction
- resp_valid  out  1  response valid
- resp_ready  in  1  pipeline accepts response
- resp_rdata  out  32  old CSR value (for rd)
- resp_redirect  out  1  resp_pc is a fetch redirect
- resp_pc  out  32  redirect target
- resp_illegal  out  1  illegal instruction detected
- csr_addr_r  out  12  CSR file read address (combinational read data returns same cycle)
- csr_data_r  in  32  CSR file read data
- csr_addr_w  out  12  CSR file write address
- csr_data_w  out  32  CSR file write data
- csr_we  out  1  CSR file write enable

Behaviour:
- States: IDLE, CSR_WR, TRAP_EPC, TRAP_CAUSE, TRAP_VEC, MRET_RD, RESP. Reset state is IDLE.
- Reset values: all registered outputs 0; req_ready=1; csr_we=0; csr_addr_r/csr_addr_w/csr_data_w=0.
- req_ready = (state==IDLE), combinational.
- IDLE, on req_valid:
  - Latch kind, funct3, csr, src, src_zero and pc.
  - kind 0 -> CSR_WR; 1 -> TRAP_EPC; 2 -> MRET_RD; 3 -> RESP with resp_illegal=1.
- CSR_WR:
  - Drive csr_addr_r=latched csr and capture old=csr_data_r into resp_rdata.
  - New value: RW/RWI -> src; RS/RSI -> old|src; RC/RCI -> old&~src.
  - Write intent = RW/RWI always; RS/RC/RSI/RCI only when !src_zero.
  - funct3 000/100 -> illegal: no write, resp_rdata=0.
  - Write intent with csr[11:10]==2'b11 (read-only) -> illegal: no write, resp_rdata=0.
  - Otherwise csr_we=1 for this one cycle when write intent holds; csr_addr_w=csr, csr_data_w=new.
  - Next state is RESP.
- TRAP_EPC: csr_we=1, csr_addr_w=MEPC_ADDR, csr_data_w=pc -> TRAP_CAUSE.
- TRAP_CAUSE: csr_we=1, csr_addr_w=MCAUSE_ADDR, csr_data_w=ECALL_CAUSE -> TRAP_VEC.
- TRAP_VEC: csr_addr_r=MTVEC_ADDR; resp_pc={csr_data_r[31:2],2'b00} (direct mode only); resp_redirect=1 -> RESP.
- MRET_RD: csr_addr_r=MEPC_ADDR; resp_pc={csr_data_r[31:2],2'b00}; resp_redirect=1 -> RESP.
- csr_we is 0 in every state except the write cycles above. csr_addr_r=0 when the state performs no read.
- RESP:
  - resp_valid=1; all resp_* fields are held stable until resp_ready.
  - On handshake: resp_valid, resp_redirect and resp_illegal clear; go to IDLE.
  - No request is accepted in the same cycle as the handshake.
- Latency (accept edge = T): CSR op resp_valid at T+2; MRET T+2; ECALL T+4; reserved kind T+1.
- At most one csr_we pulse per CSR op; exactly two per ECALL; none for MRET or illegal.
- Reset mid-sequence: async return to IDLE with outputs cleared. CSR writes already committed (e.g. mepc) stay committed; no further writes are issued.
- A write to the same address being read in CSR_WR returns the pre-write value in resp_rdata.

Test Plan:
- Reset then idle: req_ready=1, resp_valid=0, csr_we=0 for 10 cycles with req_valid=0.
- CSRRW csr=0x340, src=0xDEADBEEF, file holds 0x12345678 -> one csr_we pulse writing 0xDEADBEEF to 0x340; resp_rdata=0x12345678 at T+2.
- CSRRS csr=0x300, src_zero=1 -> csr_we never asserted, resp_rdata=old. CSRRC src=0x8, old=0x88 -> writes 0x80.
- ECALL pc=0x100, mtvec=0x2000_0001:
  - mepc=0x100 written at T+1, mcause=11 written at T+2.
  - resp_redirect=1, resp_pc=0x2000_0000 at T+4.
- MRET with mepc=0x104 -> resp_redirect=1, resp_pc=0x104 at T+2, no write. Then hold resp_ready=0 for 3 cycles: outputs stable, req_ready=0.
- Illegal cases:
  - CSRRW to 0xC00 -> resp_illegal=1, no write.
  - funct3=100 -> resp_illegal=1.
  - kind=3 -> resp_illegal=1 at T+1.
  - ECALL with rst_n low at T+2 -> only mepc written, IDLE afterwards.
